// File: rtl/mod_addsub_q.sv
// mod_addsub_q: two-stage pipelined modular adder/subtractor over Z_q (q = 3329).
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand beat handshake (in_op 0 = add, 1 = sub; in_a, in_b)
//   out_valid/out_ready  : result beat handshake (out_res residue, out_err operand >= Q)
//   op_count             : wrapping count of delivered result beats
module mod_addsub_q #(
   parameter int DATA_WID = 12,
   parameter int Q        = 3329
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_op,
   input  logic [DATA_WID-1:0] in_a,
   input  logic [DATA_WID-1:0] in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_WID-1:0] out_res,
   output logic                out_err,
   output logic [15:0]         op_count
);
   localparam logic [DATA_WID:0] QW = (DATA_WID+1)'(Q);
   logic                s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
   logic [DATA_WID:0]   s1_raw_q, s1_raw_d;
   logic                s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
   logic [DATA_WID-1:0] s2_res_q, s2_res_d;
   logic [15:0]         op_count_q, op_count_d;
   logic                adv1, adv2, ld1, ld2;
   always_comb begin
      adv2       = !s2_valid_q || out_ready;
      adv1       = !s1_valid_q || adv2;
      ld1        = adv1 && in_valid;
      ld2        = adv2 && s1_valid_q;
      s1_valid_d = adv1 ? in_valid : s1_valid_q;
      // subtraction is a + (Q - b) so the raw value stays non-negative for valid operands
      s1_raw_d   = ld1 ? (in_op ? {1'b0, in_a} + (QW - {1'b0, in_b}) : {1'b0, in_a} + {1'b0, in_b}) : s1_raw_q;
      s1_err_d   = ld1 ? ({1'b0, in_a} >= QW) || ({1'b0, in_b} >= QW) : s1_err_q;
      s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
      // single conditional subtraction, computed modulo 2^DATA_WID
      s2_res_d   = ld2 ? s1_raw_q[DATA_WID-1:0] - ((s1_raw_q >= QW) ? QW[DATA_WID-1:0] : '0) : s2_res_q;
      s2_err_d   = ld2 ? s1_err_q : s2_err_q;
      op_count_d = op_count_q + {15'd0, s2_valid_q && out_ready};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_raw_q   <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_err_q   <= 1'b0;
         op_count_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_raw_q   <= s1_raw_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_err_q   <= s2_err_d;
         op_count_q <= op_count_d;
      end
   end
   assign in_ready  = adv1;
   assign out_valid = s2_valid_q;
   assign out_res   = s2_res_q;
   assign out_err   = s2_err_q;
   assign op_count  = op_count_q;
endmodule

// File: tb/tb_mod_addsub_q.sv
// tb_mod_addsub_q: scoreboard bench for mod_addsub_q with a modular-arithmetic reference model.
module tb_mod_addsub_q;
   localparam int QM = 3329;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_op = 1'b0;
   logic [11:0] in_a = '0;
   logic [11:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] out_res;
   logic        out_err;
   logic [15:0] op_count;
   logic [12:0] sb[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_cnt = 0;
   bit          bp_mode = 1'b0;
   bit          ready_force = 1'b1;

   mod_addsub_q dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_err(out_err), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // downstream readiness changes only at posedge+2
   initial forever begin
      @(posedge clk);
      #2;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // monitor: a handshake seen at the negedge completes on the following posedge
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_cnt = 0;
      end else if (out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got res=%0d err=%0d, required no beat", out_res, out_err);
         end else begin
            logic [12:0] e;
            e = sb.pop_front();
            if ({out_err, out_res} !== e) begin
               failures++;
               $display("FAIL result: got res=%0d err=%0d, required res=%0d err=%0d",
                        out_res, out_err, e[11:0], e[12]);
            end
         end
         checks++;
         if (op_count !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL op_count_live: got %0d, required %0d", op_count, 16'(exp_cnt));
         end
         exp_cnt++;
      end
   end

   function automatic logic [12:0] model(bit op, int a, int b);
      int r;
      bit e;
      e = (a >= QM) || (b >= QM);
      if (!e) r = op ? (a - b + QM) % QM : (a + b) % QM;
      else begin
         r = (op ? a + QM - b : a + b) & 8191;
         if (r >= QM) r -= QM;
         r &= 4095;
      end
      return {e, 12'(r)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // entered at posedge+1, returns at posedge+1 after the accepting edge
   task automatic send(input bit op, input int a, input int b, input int r, input bit e);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_op = op;
      in_a = 12'(a);
      in_b = 12'(b);
      #2;
      while (!in_ready && t < 500) begin
         @(posedge clk);
         #3;
         t++;
      end
      if (t >= 500) begin
         chk("in_ready_timeout", 0, 1);
      end else begin
         sb.push_back({e, 12'(r)});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      bit op;
      int a, b;
      logic [12:0] m;
      op = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, QM - 1));
      b = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, QM - 1));
      m = model(op, a, b);
      send(op, a, b, int'(m[11:0]), m[12]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 1000) chk("drain_timeout", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      ready_force = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_res", int'(out_res), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_op_count", int'(op_count), 0);
      chk("rst_in_ready", int'(in_ready), 1);

      send(0, 10, 20, 30, 0);
      chk("lat_not_yet", int'(out_valid), 0);
      @(posedge clk);
      #1;
      chk("lat_valid", int'(out_valid), 1);
      chk("lat_res", int'(out_res), 30);
      @(posedge clk);
      #1;
      chk("lat_op_count", int'(op_count), 1);

      do_reset();
      send(0, 3328, 1, 0, 0);
      send(0, 3328, 3328, 3327, 0);
      send(0, 256, 0, 256, 0);
      send(1, 0, 1, 3328, 0);
      send(1, 20, 10, 10, 0);
      send(1, 5, 5, 0, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("stream_drained", sb.size(), 0);
      chk("stream_op_count", int'(op_count), 6);

      ready_force = 1'b0;
      send(0, 100, 200, 300, 0);
      send(1, 7, 9, 3327, 0);
      in_valid = 1'b1;
      in_op = 1'b0;
      in_a = 12'd3000;
      in_b = 12'd500;
      #2;
      chk("full_in_ready", int'(in_ready), 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_res", int'(out_res), 300);
      end
      ready_force = 1'b1;
      send(0, 3000, 500, 171, 0);
      send(0, 1, 1, 2, 0);
      wait_drain();

      send(0, 3329, 3329, 3329, 1);
      send(0, 1, 2, 3, 0);
      wait_drain();

      ready_force = 1'b0;
      send(0, 11, 12, 23, 0);
      send(0, 13, 14, 27, 0);
      do_reset();
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_op_count", int'(op_count), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      ready_force = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      send(0, 4, 5, 9, 0);
      wait_drain();
      chk("post_rst_op_count", int'(op_count), 1);

      bp_mode = 1'b1;
      repeat (300) send_rand();
      bp_mode = 1'b0;
      wait_drain();

      do_reset();
      repeat (65536) send_rand();
      wait_drain();
      chk("wrap_op_count", int'(op_count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
